// File: rtl/fetch_split_ctrl_pkg.sv
// Shared core1 definitions for the fetch sequencer: state encoding,
// instruction field positions and the default halt opcode.
package fetch_split_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned OP_MSB   = 23;
  localparam int unsigned OP_LSB   = 16;
  localparam int unsigned FLAG_BIT = 24;

  localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;

endpackage

// File: rtl/fetch_split_ctrl_split.sv
// Instruction field splitter: slices a 32-bit instruction word into
// imm16, opcode and flag. Purely combinational.
module fetch_split_ctrl_split
  import fetch_split_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output logic [15:0] imm16,
  output logic [7:0]  opcode,
  output logic        flag
);

  assign imm16  = ir[IMM_MSB:IMM_LSB];
  assign opcode = ir[OP_MSB:OP_LSB];
  assign flag   = ir[FLAG_BIT];

endmodule

// File: rtl/fetch_split_ctrl.sv
// Fetch sequencer: fetches instruction words over req/ack into the IR,
// issues the split fields over valid/ready, owns the PC, and handles
// branch redirect and the halt opcode.
module fetch_split_ctrl
  import fetch_split_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [7:0]        HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [15:0]       imm16,
  output logic [7:0]        opcode,
  output logic              flag,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              halted
);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [31:0]       ir;
  logic              ir_load;

  fetch_split_ctrl_split u_split (
    .ir     (ir),
    .imm16  (imm16),
    .opcode (opcode),
    .flag   (flag)
  );

  // Next-state, next-PC and IR load decisions.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem_ack) begin
          ir_load    = 1'b1;
          pc_next    = pc + ADDR_W'(1);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ins_ready) begin
          if (opcode == HALT_OPCODE) begin
            state_next = ST_HALT;
          end else begin
            if (branch_valid) pc_next = branch_addr;
            state_next = en ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, PC, IR and registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= START_ADDR;
      ir        <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      if (ir_load) ir <= mem_rdata;
      mem_req   <= (state_next == ST_REQ);
      ins_valid <= (state_next == ST_ISSUE);
      halted    <= (state_next == ST_HALT);
      if (state_next == ST_REQ) mem_addr <= pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_split_ctrl.sv
// Self-checking bench for fetch_split_ctrl: direct checks of handshake
// timing plus a scoreboard of expected issued fields.
module tb_fetch_split_ctrl;

  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              ins_valid;
  logic              ins_ready;
  logic [15:0]       imm16;
  logic [7:0]        opcode;
  logic              flag;
  logic [ADDR_W-1:0] pc;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_addr;
  logic              halted;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Expected issued fields: {flag, opcode, imm16}
  logic [24:0] sb_q[$];

  fetch_split_ctrl #(
    .ADDR_W      (8),
    .START_ADDR  (8'h00),
    .HALT_OPCODE (8'hFF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .imm16        (imm16),
    .opcode       (opcode),
    .flag         (flag),
    .pc           (pc),
    .branch_valid (branch_valid),
    .branch_addr  (branch_addr),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Compare one handshake against the scoreboard head.
  task automatic sb_sample();
    logic [24:0] e;
    if (!rst && ins_valid === 1'b1 && ins_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_fields", {7'd0, flag, opcode, imm16}, {7'd0, e});
      end
    end
  endtask

  // Sample handshakes at the falling edge, then advance past the rising edge.
  task automatic tick();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [31:0] w, input bit issues);
    mem_ack   = 1'b1;
    mem_rdata = w;
    if (issues) sb_q.push_back(w[24:0]);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    ins_ready = 1'b0; branch_valid = 1'b0; branch_addr = '0;
    @(posedge clk); #1;
    tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_ins_valid", 32'(ins_valid), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_fields", {7'd0, flag, opcode, imm16}, 32'h0);

    // First request one cycle after reset release
    rst = 1'b0;
    tick();
    check("first_req", 32'(mem_req), 32'h1);
    check("first_addr", 32'(mem_addr), 32'h0);

    // Zero-wait fetches
    ins_ready = 1'b1;
    ack_word(32'h01AA1234, 1'b1);
    tick();
    mem_ack = 1'b0;
    check("zw_valid0", 32'(ins_valid), 32'h1);
    check("zw_req_low", 32'(mem_req), 32'h0);
    check("zw_pc1", 32'(pc), 32'h1);
    tick();
    check("zw_req1", 32'(mem_req), 32'h1);
    check("zw_addr1", 32'(mem_addr), 32'h1);
    ack_word(32'h00550001, 1'b1);
    tick();
    mem_ack = 1'b0;
    check("zw_valid1", 32'(ins_valid), 32'h1);
    tick();
    check("zw_pc2", 32'(pc), 32'h2);
    check("zw_addr2", 32'(mem_addr), 32'h2);

    // Wait states: request held while ack is delayed
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_req_held", 32'(mem_req), 32'h1);
      check("ws_addr_held", 32'(mem_addr), 32'h2);
      check("ws_no_valid", 32'(ins_valid), 32'h0);
    end
    ins_ready = 1'b0;
    ack_word(32'h0012ABCD, 1'b1);
    tick();
    mem_ack = 1'b0;
    check("ws_valid_after_ack", 32'(ins_valid), 32'h1);

    // Backpressure: fields stable and no request while ready is low
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(ins_valid), 32'h1);
      check("bp_fields", {7'd0, flag, opcode, imm16}, 32'h0012ABCD);
      check("bp_no_req", 32'(mem_req), 32'h0);
      tick();
    end
    ins_ready = 1'b1;
    tick();
    check("bp_next_req", 32'(mem_req), 32'h1);
    check("bp_next_addr", 32'(mem_addr), 32'h3);
    check("bp_valid_low", 32'(ins_valid), 32'h0);

    // Branch to 0xFF
    ack_word(32'h00010000, 1'b1);
    tick();
    mem_ack = 1'b0;
    branch_valid = 1'b1; branch_addr = 8'hFF;
    tick();
    branch_valid = 1'b0;
    check("br_addr_ff", 32'(mem_addr), 32'hFF);
    check("br_pc_ff", 32'(pc), 32'hFF);

    // Branch pulse during REQ has no effect
    branch_valid = 1'b1; branch_addr = 8'h80;
    tick();
    branch_valid = 1'b0;
    check("br_req_ignored_addr", 32'(mem_addr), 32'hFF);
    check("br_req_ignored_pc", 32'(pc), 32'hFF);

    // PC wraps on the fetch at 0xFF
    ack_word(32'h00020000, 1'b1);
    tick();
    mem_ack = 1'b0;
    check("wrap_pc", 32'(pc), 32'h00);
    branch_valid = 1'b1; branch_addr = 8'h40;
    tick();
    branch_valid = 1'b0;
    check("br40_addr", 32'(mem_addr), 32'h40);
    check("br40_req", 32'(mem_req), 32'h1);

    // Halt opcode: branch ignored, no further fetches
    ack_word(32'h00FF0000, 1'b1);
    tick();
    mem_ack = 1'b0;
    branch_valid = 1'b1; branch_addr = 8'h10;
    tick();
    branch_valid = 1'b0;
    check("halt_flag", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h41);
    for (int i = 0; i < 3; i++) begin
      ack_word(32'h01234567, 1'b0);
      tick();
      mem_ack = 1'b0;
      check("halt_no_req", 32'(mem_req), 32'h0);
      check("halt_no_valid", 32'(ins_valid), 32'h0);
      check("halt_held", 32'(halted), 32'h1);
      check("halt_ack_ignored", {7'd0, flag, opcode, imm16}, 32'h00FF0000);
      check("halt_pc_held", 32'(pc), 32'h41);
    end

    // Reset exits halt; then reset mid-REQ abandons the request
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rst2_req", 32'(mem_req), 32'h1);
    check("rst2_halted", 32'(halted), 32'h0);
    rst = 1'b1;
    tick();
    check("midreq_rst_req", 32'(mem_req), 32'h0);
    rst = 1'b0; en = 1'b0;
    ack_word(32'h01BB7777, 1'b0);
    tick();
    mem_ack = 1'b0;
    check("late_ack_fields", {7'd0, flag, opcode, imm16}, 32'h0);
    check("late_ack_valid", 32'(ins_valid), 32'h0);
    check("late_ack_pc", 32'(pc), 32'h0);
    check("idle_no_req", 32'(mem_req), 32'h0);

    // en falls during REQ: word still fetched and issued, then IDLE
    en = 1'b1;
    tick();
    en = 1'b0;
    check("en_req", 32'(mem_req), 32'h1);
    tick();
    check("en_low_req_held", 32'(mem_req), 32'h1);
    ack_word(32'h00330044, 1'b1);
    tick();
    mem_ack = 1'b0;
    check("en_low_issue", 32'(ins_valid), 32'h1);
    tick();
    check("en_low_idle_req", 32'(mem_req), 32'h0);
    check("en_low_idle_valid", 32'(ins_valid), 32'h0);
    check("en_low_pc", 32'(pc), 32'h1);
    tick();
    check("en_low_stays_idle", 32'(mem_req), 32'h0);

    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
